// File: rtl/skid_fifo_pkg.sv
// rtl/skid_fifo_pkg.sv - shared width and pointer helpers for pointer-based buffers
package skid_fifo_pkg;

  function automatic int width_of(int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Pointers wrap at DEPTH-1, so DEPTH does not have to be a power of two.
  function automatic int wrap_inc(int p, int depth);
    return (p == depth - 1) ? 0 : p + 1;
  endfunction

endpackage

// File: rtl/fifo_regfile.sv
// rtl/fifo_regfile.sv - DEPTH x DATA_SIZE register array, one write port, async read
module fifo_regfile #(
  parameter int DATA_SIZE = 32,
  parameter int DEPTH     = 4,
  parameter int PTR_W     = 2
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [PTR_W-1:0]     waddr,
  input  logic [DATA_SIZE-1:0] wdata,
  input  logic [PTR_W-1:0]     raddr,
  output logic [DATA_SIZE-1:0] rdata
);

  logic [DATA_SIZE-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/skid_fifo.sv
// rtl/skid_fifo.sv - N-entry first-word-fall-through elastic buffer with flush and overflow
module skid_fifo
  import skid_fifo_pkg::*;
#(
  parameter  int DATA_SIZE = 32,
  parameter  int DEPTH     = 4,
  parameter  int AFULL_TH  = DEPTH - 1,
  localparam int PTR_W     = width_of(DEPTH),
  localparam int CNT_W     = width_of(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 req,
  input  logic [DATA_SIZE-1:0] d_i,
  output logic                 in_ready,
  output logic                 valid,
  input  logic                 ready,
  output logic [DATA_SIZE-1:0] d_o,
  output logic [CNT_W-1:0]     count,
  output logic                 almost_full,
  output logic                 overflow
);

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             push;
  logic             pop;

  // Status flags come from registered count only, keeping ready->in_ready and req->valid cut.
  assign in_ready    = (count != CNT_W'(DEPTH));
  assign valid       = (count != '0);
  assign almost_full = (count >= CNT_W'(AFULL_TH));

  assign push = req & in_ready & ~flush;
  assign pop  = valid & ready & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= PTR_W'(wrap_inc(int'(wr_ptr), DEPTH));
      if (pop)  rd_ptr <= PTR_W'(wrap_inc(int'(rd_ptr), DEPTH));
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
      if (req && !in_ready) overflow <= 1'b1;
    end
  end

  fifo_regfile #(
    .DATA_SIZE (DATA_SIZE),
    .DEPTH     (DEPTH),
    .PTR_W     (PTR_W)
  ) u_regfile (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (d_i),
    .raddr (rd_ptr),
    .rdata (d_o)
  );

endmodule

// File: tb/tb_skid_fifo.sv
// tb/tb_skid_fifo.sv - DEPTH=4 and DEPTH=3 skid_fifo against a queue reference model
module tb_skid_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        req;
  logic [31:0] d_i;
  logic        ready;

  logic        in_ready [2];
  logic        vld      [2];
  logic [31:0] dout     [2];
  logic        afull    [2];
  logic        ovf      [2];
  logic [2:0]  cnt4;
  logic [1:0]  cnt3;

  logic [31:0] mq [2][$];
  int          mdepth [2] = '{4, 3};
  bit          movf [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  skid_fifo #(.DATA_SIZE(32), .DEPTH(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .req(req), .d_i(d_i),
    .in_ready(in_ready[0]), .valid(vld[0]), .ready(ready), .d_o(dout[0]),
    .count(cnt4), .almost_full(afull[0]), .overflow(ovf[0])
  );

  skid_fifo #(.DATA_SIZE(32), .DEPTH(3)) u_d3 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .req(req), .d_i(d_i),
    .in_ready(in_ready[1]), .valid(vld[1]), .ready(ready), .d_o(dout[1]),
    .count(cnt3), .almost_full(afull[1]), .overflow(ovf[1])
  );

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] count_of(int k);
    return (k == 0) ? {29'd0, cnt4} : {30'd0, cnt3};
  endfunction

  task automatic check_state(string tag);
    for (int k = 0; k < 2; k++) begin
      int n = mq[k].size();
      check($sformatf("%s.d%0d.count", tag, mdepth[k]), count_of(k), n);
      check($sformatf("%s.d%0d.valid", tag, mdepth[k]), vld[k], (n != 0));
      check($sformatf("%s.d%0d.in_ready", tag, mdepth[k]), in_ready[k], (n < mdepth[k]));
      check($sformatf("%s.d%0d.afull", tag, mdepth[k]), afull[k], (n >= mdepth[k] - 1));
      check($sformatf("%s.d%0d.overflow", tag, mdepth[k]), ovf[k], movf[k]);
      if (n != 0) check($sformatf("%s.d%0d.d_o", tag, mdepth[k]), dout[k], mq[k][0]);
    end
  endtask

  // Called just after a falling edge: drives one cycle, advances the model, checks after the edge.
  task automatic cyc(string tag, bit r, logic [31:0] d, bit rd, bit fl);
    bit full;
    req = r; d_i = d; ready = rd; flush = fl;
    for (int k = 0; k < 2; k++) begin
      if (fl) begin
        mq[k].delete();
        movf[k] = 1'b0;
      end else begin
        full = (mq[k].size() == mdepth[k]);
        if (rd && mq[k].size() != 0) begin
          check($sformatf("%s.d%0d.pop_data", tag, mdepth[k]), dout[k], mq[k][0]);
          void'(mq[k].pop_front());
        end
        if (r && full)  movf[k] = 1'b1;
        if (r && !full) mq[k].push_back(d);
      end
    end
    @(posedge clk);
    @(negedge clk);
    req = 1'b0; ready = 1'b0; flush = 1'b0;
    check_state(tag);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; req = 1'b0; d_i = '0; ready = 1'b0;
    repeat (2) @(negedge clk);
    check_state("reset");
    check("reset.in_ready", in_ready[0], 1);
    rst_n = 1'b1;

    // Three pushes with ready low, then drain in order.
    cyc("t1.push", 1, 32'h11, 0, 0);
    cyc("t1.push", 1, 32'h22, 0, 0);
    cyc("t1.push", 1, 32'h33, 0, 0);
    check("t1.count3", cnt4, 3);
    check("t1.afull", afull[0], 1);
    check("t1.head", dout[0], 32'h11);
    cyc("t1.pop", 0, 0, 1, 0);
    check("t1.head2", dout[0], 32'h22);
    cyc("t1.pop", 0, 0, 1, 0);
    check("t1.head3", dout[0], 32'h33);
    cyc("t1.pop", 0, 0, 1, 0);
    check("t1.empty", vld[0], 0);

    // Fill, push while full, drain.
    for (int i = 0; i < 4; i++) cyc("t2.fill", 1, 32'hA0 + i, 0, 0);
    cyc("t2.over", 1, 32'hAA, 0, 0);
    check("t2.ovf", ovf[0], 1);
    check("t2.count", cnt4, 4);
    check("t2.in_ready", in_ready[0], 0);
    cyc("t2.full_pushpop", 1, 32'hAB, 1, 0);
    for (int i = 0; i < 4; i++) cyc("t2.drain", 0, 0, 1, 0);

    // Steady count=2 with simultaneous push/pop across wrap.
    cyc("t3.pre", 1, 32'hF0, 0, 0);
    cyc("t3.pre", 1, 32'hF1, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      cyc("t3.stream", 1, i, 1, 0);
      check("t3.count", cnt4, 2);
    end
    cyc("t3.drain", 0, 0, 1, 0);
    cyc("t3.drain", 0, 0, 1, 0);

    // Two pushes then one pop, repeated; wraps the DEPTH=3 pointers.
    for (int i = 0; i < 5; i++) begin
      cyc("t4.push", 1, 32'h40 + i, 0, 0);
      if (i % 2 == 1) cyc("t4.pop", 0, 0, 1, 0);
    end
    for (int i = 0; i < 3; i++) cyc("t4.drain", 0, 0, 1, 0);

    // Flush against a full/overflowed buffer with req and ready high.
    for (int i = 0; i < 4; i++) cyc("t5.fill", 1, 32'h50 + i, 0, 0);
    check("t5.ovf_pre", ovf[1], 1);
    cyc("t5.flush", 1, 32'hDD, 1, 1);
    check("t5.count", cnt4, 0);
    check("t5.ovf", ovf[0], 0);
    cyc("t5.after", 1, 32'h5A, 0, 0);
    check("t5.head", dout[0], 32'h5A);
    cyc("t5.drain", 0, 0, 1, 0);

    // Asynchronous reset in the middle of a cycle.
    cyc("t6.push", 1, 32'h61, 0, 0);
    cyc("t6.push", 1, 32'h62, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      movf[k] = 1'b0;
    end
    check_state("t6.async");
    @(negedge clk);
    rst_n = 1'b1;
    cyc("t6.push55", 1, 32'h55, 0, 0);
    check("t6.head", dout[0], 32'h55);
    cyc("t6.drain", 0, 0, 1, 0);

    // Randomized traffic with occasional flush.
    for (int i = 0; i < 400; i++) begin
      cyc("rnd", ($urandom_range(0, 99) < 60), $urandom, ($urandom_range(0, 99) < 50),
          ($urandom_range(0, 99) < 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/skid_fifo.md
Name: skid_fifo

Overview:
Parametrised successor to the two-entry split register: an N-entry first-word-fall-through elastic buffer for pipeline decoupling between compute stages and memory/read-data paths.
- Adds upstream back-pressure (in_ready), occupancy count, almost-full threshold, synchronous flush and a sticky overflow flag.
- Sits between any producer that issues single-cycle push strobes and a valid/ready consumer.

Parameters:
DATA_SIZE, 32, payload width in bits
DEPTH, 4, number of entries; legal range >= 2; need not be a power of two
AFULL_TH, DEPTH-1, almost_full asserts when count >= AFULL_TH; legal range 1..DEPTH
PTR_W, $clog2(DEPTH), read/write pointer width (derived, not overridden)
CNT_W, $clog2(DEPTH+1), occupancy counter width (derived, not overridden)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
flush  input  1  synchronous clear of all entries
req  input  1  push strobe; d_i is written when req & in_ready
d_i  input  DATA_SIZE  push data
in_ready  output  1  space available (count < DEPTH)
valid  output  1  head entry present (count != 0)
ready  input  1  consumer accepts head this cycle
d_o  output  DATA_SIZE  head data (fall-through)
count  output  CNT_W  current occupancy
almost_full  output  1  count >= AFULL_TH
overflow  output  1  sticky: a push was attempted while full

Behaviour:
- Reset (rst_n low, asynchronous):
  - rd_ptr, wr_ptr, count and overflow clear to 0.
  - Outputs: valid=0, in_ready=1, almost_full=0.
  - Storage array is not reset.
- Handshake events:
  - push = req & in_ready & ~flush.
  - pop = valid & ready & ~flush.
- Combinational paths: in_ready, valid and almost_full derive only from registered count. There is no combinational path from ready to in_ready or from req to valid.
- Push: mem[wr_ptr] <= d_i; wr_ptr advances.
- Pop: rd_ptr advances.
- Pointer wrap: a pointer at DEPTH-1 wraps to 0.
- Count update: count +1 on push only, -1 on pop only, unchanged when both or neither occur.
- Latency: data pushed in cycle T is visible at d_o with valid=1 in cycle T+1 if the FIFO was empty at T. Minimum latency is 1 cycle; there is no bypass.
- Ordering: strict FIFO order is preserved across wrap-around.
- Full (count==DEPTH):
  - in_ready=0, and a push is not accepted even if a pop occurs in the same cycle.
  - req=1 while in_ready=0 drops d_i and sets overflow.
  - overflow stays set until flush or reset.
- Empty (count==0):
  - valid=0; ready is ignored.
  - d_o is don't-care; the bench must not check it.
  - A push while empty does not pop in the same cycle.
- Simultaneous push and pop with 0 < count < DEPTH: count holds and both pointers advance.
- Flush:
  - Next edge: pointers, count and overflow become 0.
  - Flush has priority over push and pop in the same cycle; a req in the flush cycle is discarded and does not set overflow.
- Reset mid-transfer: all in-flight entries are lost. The first valid after reset release is the first accepted push.
- d_o stability: d_o is stable while valid=1 and ready=0. It changes only on a pop or on the first push into an empty FIFO.

Decomposition:
- Shared header:
  - a clog2-based width macro for PTR_W/CNT_W;
  - a wrap-increment function, next = (p == DEPTH-1) ? 0 : p+1, reused by other pointer-based blocks.
- One natural sub-module: fifo_regfile. It is a DEPTH x DATA_SIZE register array with one write port (we, waddr, wdata) and one asynchronous read port (raddr, rdata), and no reset.
- Control (pointers, count, flags) lives in skid_fifo.

Test Plan:
1. Reset, then push 0x11, 0x22, 0x33 on consecutive cycles with ready=0 (DEPTH=4) -> count=3, almost_full=1, d_o=0x11. Set ready=1 -> d_o 0x11, 0x22, 0x33 on successive cycles, then valid=0 and count=0.
2. Fill 4 entries, then req=1 with d_i=0xAA and ready=0 -> in_ready=0, overflow=1, count stays 4. Drain -> exactly the 4 original values, no 0xAA.
3. Hold count=2 with req=1 and ready=1 for 10 cycles, pushing 1..10 -> count stays 2 throughout, and the output sequence is in order with no gaps across pointer wrap.
4. DEPTH=3 build: push 5 values while popping 1 after each 2 pushes -> pointers wrap 2->0, output order matches input order, and in_ready deasserts exactly at count=3.
5. With count=3 and overflow=1, assert flush together with req=1 and ready=1 -> next cycle count=0, valid=0, overflow=0, and the flush-cycle data is absent.
6. Deassert rst_n asynchronously mid-cycle with count=2 -> valid=0, in_ready=1 and count=0 immediately, without waiting for a clock edge. After release, push 0x55 -> d_o=0x55 one cycle later.
